// File: rtl/serial_rf_transmitter.sv
// Serial RF link transmitter: frames one byte as preamble, start, 8 data bits
// (LSB first), optional even parity and stop, at BIT_CYCLES clocks per bit.
//
// state      | meaning
// S_IDLE     | line idle at 1, waiting for Send
// S_PREAMBLE | alternating 0,1,... slicer training bits
// S_START    | start bit (0)
// S_DATA     | 8 data bits, shift register LSB first
// S_PARITY   | even parity of the latched byte
// S_STOP     | stop bit (1); its terminal count pulses Done
module serial_rf_transmitter #(
  parameter int unsigned BIT_CYCLES   = 4166667,
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] Data,
  input  logic       Send,
  output logic       SB,
  output logic       Busy,
  output logic       Done
);

  localparam int unsigned      BIT_W     = $clog2(PREAMBLE_LEN + 12);
  localparam logic [31:0]      DIV_LAST  = 32'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_LEN - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(7);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t           r_state;
  logic [31:0]      r_div;
  logic [BIT_W-1:0] r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic             r_sb;
  logic             r_busy;
  logic             r_done;
  logic             w_tc;

  assign w_tc = (r_div == DIV_LAST);
  assign SB   = r_sb;
  assign Busy = r_busy;
  assign Done = r_done;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_sb      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div <= '0;
        if (Send) begin
          r_shift   <= Data;
          r_parity  <= ^Data;
          r_bit_idx <= '0;
          r_busy    <= 1'b1;
          // Both the preamble and the start bit begin with 0.
          r_sb      <= 1'b0;
          r_state   <= (PREAMBLE_LEN == 0) ? S_START : S_PREAMBLE;
        end
      end else if (!w_tc) begin
        r_div <= r_div + 32'd1;
      end else begin
        r_div <= '0;
        case (r_state)
          S_PREAMBLE: begin
            if (r_bit_idx == PRE_LAST) begin
              r_state   <= S_START;
              r_bit_idx <= '0;
              r_sb      <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_ONE;
              r_sb      <= ~r_sb;
            end
          end
          S_START: begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_sb      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
          end
          S_DATA: begin
            if (r_bit_idx == DATA_LAST) begin
              r_bit_idx <= '0;
              if (PARITY_EN) begin
                r_state <= S_PARITY;
                r_sb    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_sb    <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + BIT_ONE;
              r_sb      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end
          S_PARITY: begin
            r_state <= S_STOP;
            r_sb    <= 1'b1;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sb    <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sb    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
